// File: rtl/soc_rtc_timer.sv
// soc_rtc_timer: word-addressed real-time counter with prescaler, N compare alarms, overflow flag, W1C status and level irq.
// Optional RTC_EXT_TICK_EN: prescaler counts synchronised rising edges of rtc_tick_in instead of clk cycles.
module soc_rtc_timer #(
  parameter int IO_MAP_WIDTH   = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int PRESCALE_WIDTH = 16,
  parameter int N_ALARMS       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   rtc_addr,
  input  logic [IO_MAP_WIDTH-1:0] rtc_wdata,
  input  logic                    rtc_we,
  input  logic                    rtc_re,
`ifdef RTC_EXT_TICK_EN
  input  logic                    rtc_tick_in,
`endif
  output logic [IO_MAP_WIDTH-1:0] rtc_rdata,
  output logic                    rtc_ready,
  output logic                    rtc_irq
);
  localparam int W = IO_MAP_WIDTH;

  logic                      en_q, en_d;
  logic [N_ALARMS-1:0]       aie_q, aie_d;
  logic                      oie_q, oie_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
  logic [W-1:0]              count_q, count_d;
  logic [N_ALARMS-1:0]       apend_q, apend_d;
  logic                      opend_q, opend_d;
  logic [W-1:0]              alarm_q [N_ALARMS];
  logic [W-1:0]              alarm_d [N_ALARMS];
  logic [W-1:0]              rdata_q, rdata_d;
  logic                      ready_q, ready_d;
  logic                      pulse, tick, wr_count;
  logic [W-1:0]              count_inc, rd;

  // Bit n of v; positions beyond the bus width read as 0 so narrow builds stay legal.
  function automatic logic wbit(input logic [W-1:0] v, input int n);
    logic [W-1:0] sh;
    sh = v >> n;
    return sh[0];
  endfunction

  function automatic logic [W-1:0] bitv(input logic b, input int n);
    return {{(W-1){1'b0}}, b} << n;
  endfunction

`ifdef RTC_EXT_TICK_EN
  // [0],[1] synchroniser, [2] previous level, [3] registered rising-edge pulse
  logic [3:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1] & ~sync_q[2], sync_q[1], sync_q[0], rtc_tick_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign pulse = en_q & sync_q[3];
`else
  assign pulse = en_q;
`endif

  always_comb begin
    en_d       = en_q;
    aie_d      = aie_q;
    oie_d      = oie_q;
    prescale_d = prescale_q;
    psc_d      = psc_q;
    count_d    = count_q;
    apend_d    = apend_q;
    opend_d    = opend_q;
    for (int i = 0; i < N_ALARMS; i++) alarm_d[i] = alarm_q[i];
    tick      = pulse && (psc_q == prescale_q);
    wr_count  = rtc_we && (rtc_addr == ADDR_WIDTH'(2));
    count_inc = count_q + W'(1);

    if (pulse) psc_d = tick ? '0 : psc_q + PRESCALE_WIDTH'(1);

    if (rtc_we) begin
      if (rtc_addr == ADDR_WIDTH'(0)) begin
        en_d = rtc_wdata[0];
        for (int i = 0; i < N_ALARMS; i++) aie_d[i] = wbit(rtc_wdata, 8 + i);
        oie_d = wbit(rtc_wdata, 16);
      end
      if (rtc_addr == ADDR_WIDTH'(1)) begin
        prescale_d = rtc_wdata[PRESCALE_WIDTH-1:0];
        psc_d      = '0;
      end
      if (wr_count) count_d = rtc_wdata;
      if (rtc_addr == ADDR_WIDTH'(3)) begin
        for (int i = 0; i < N_ALARMS; i++) if (wbit(rtc_wdata, i)) apend_d[i] = 1'b0;
        if (wbit(rtc_wdata, 16)) opend_d = 1'b0;
      end
      for (int i = 0; i < N_ALARMS; i++)
        if (rtc_addr == ADDR_WIDTH'(4 + i)) alarm_d[i] = rtc_wdata;
    end

    // Set events are applied after W1C clears so a coincident set wins.
    if (tick && !wr_count) begin
      count_d = count_inc;
      if (count_q == '1) opend_d = 1'b1;
      for (int i = 0; i < N_ALARMS; i++) if (count_inc == alarm_q[i]) apend_d[i] = 1'b1;
    end

    rd = '0;
    if (rtc_addr == ADDR_WIDTH'(0)) begin
      rd = bitv(en_q, 0) | bitv(oie_q, 16);
      for (int i = 0; i < N_ALARMS; i++) rd = rd | bitv(aie_q[i], 8 + i);
    end
    if (rtc_addr == ADDR_WIDTH'(1)) rd = W'(prescale_q);
    if (rtc_addr == ADDR_WIDTH'(2)) rd = count_q;
    if (rtc_addr == ADDR_WIDTH'(3)) begin
      rd = bitv(opend_q, 16);
      for (int i = 0; i < N_ALARMS; i++) rd = rd | bitv(apend_q[i], i);
    end
    for (int i = 0; i < N_ALARMS; i++)
      if (rtc_addr == ADDR_WIDTH'(4 + i)) rd = alarm_q[i];

    rdata_d = rtc_re ? rd : rdata_q;
    ready_d = rtc_re | rtc_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      aie_q      <= '0;
      oie_q      <= 1'b0;
      prescale_q <= '0;
      psc_q      <= '0;
      count_q    <= '0;
      apend_q    <= '0;
      opend_q    <= 1'b0;
      for (int i = 0; i < N_ALARMS; i++) alarm_q[i] <= '1;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      en_q       <= en_d;
      aie_q      <= aie_d;
      oie_q      <= oie_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      count_q    <= count_d;
      apend_q    <= apend_d;
      opend_q    <= opend_d;
      for (int i = 0; i < N_ALARMS; i++) alarm_q[i] <= alarm_d[i];
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
    end
  end

  assign rtc_rdata = rdata_q;
  assign rtc_ready = ready_q;
  assign rtc_irq   = (|(apend_q & aie_q)) | (opend_q & oie_q);

endmodule

// File: tb/tb_soc_rtc_timer.sv
// Bench for soc_rtc_timer: random register traffic scored against a behavioural model; read data checked by a ready-driven monitor.
module tb_soc_rtc_timer;
  localparam int W = 32, AW = 4, PW = 16, NA = 2;
`ifdef RTC_EXT_TICK_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] rtc_addr = '0;
  logic [W-1:0]  rtc_wdata = '0;
  logic          rtc_we = 1'b0, rtc_re = 1'b0;
  logic [W-1:0]  rtc_rdata;
  logic          rtc_ready, rtc_irq;
`ifdef RTC_EXT_TICK_EN
  logic          rtc_tick_in = 1'b0;
`endif

  soc_rtc_timer #(.IO_MAP_WIDTH(W), .ADDR_WIDTH(AW), .PRESCALE_WIDTH(PW), .N_ALARMS(NA)) dut (
    .clk(clk), .rst_n(rst_n), .rtc_addr(rtc_addr), .rtc_wdata(rtc_wdata),
    .rtc_we(rtc_we), .rtc_re(rtc_re),
`ifdef RTC_EXT_TICK_EN
    .rtc_tick_in(rtc_tick_in),
`endif
    .rtc_rdata(rtc_rdata), .rtc_ready(rtc_ready), .rtc_irq(rtc_irq));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_en, m_oie, m_opend;
  bit [NA-1:0]  m_aie, m_apend;
  logic [W-1:0] m_psc, m_cnt;
  logic [W-1:0] m_alarm [NA];
  int           m_phase;      // enabled source pulses since the last tick
  bit [3:0]     m_hist;       // external edges, aged one clock per step
  bit           ext_next = 1'b0, ext_lvl = 1'b0;

  task automatic model_reset();
    m_en = 0; m_oie = 0; m_opend = 0; m_aie = '0; m_apend = '0;
    m_psc = '0; m_cnt = '0; m_phase = 0; m_hist = '0;
    for (int i = 0; i < NA; i++) m_alarm[i] = '1;
  endtask

  function automatic logic [W-1:0] model_read(input int a);
    if (a == 0) return W'(m_en) | (W'(m_aie) << 8) | (W'(m_oie) << 16);
    if (a == 1) return m_psc;
    if (a == 2) return m_cnt;
    if (a == 3) return W'(m_apend) | (W'(m_opend) << 16);
    if (a >= 4 && a < 4 + NA) return m_alarm[a-4];
    return '0;
  endfunction

  function automatic bit model_irq();
    return (|(m_apend & m_aie)) || (m_opend && m_oie);
  endfunction

  task automatic model_step(input bit we, input int a, input logic [W-1:0] wd, input bit rise);
    bit src, tk, oset;
    bit [NA-1:0] aset;
    logic [W-1:0] nxt;
    m_hist = {m_hist[2:0], rise};
    src = EXT ? m_hist[3] : 1'b1;
    tk = 0; oset = 0; aset = '0;
    if (m_en && src) begin
      m_phase++;
      if (m_phase == int'(m_psc) + 1) begin tk = 1; m_phase = 0; end
    end
    if (tk && !(we && a == 2)) begin
      nxt  = m_cnt + 1;
      oset = (nxt == 0);
      for (int i = 0; i < NA; i++) aset[i] = (nxt == m_alarm[i]);
      m_cnt = nxt;
    end
    if (we) begin
      if (a == 0) begin m_en = wd[0]; m_aie = wd[8 +: NA]; m_oie = wd[16]; end
      if (a == 1) begin m_psc = wd & W'((64'd1 << PW) - 1); m_phase = 0; end
      if (a == 2) m_cnt = wd;
      if (a == 3) begin m_apend = m_apend & ~wd[NA-1:0]; if (wd[16]) m_opend = 0; end
      if (a >= 4 && a < 4 + NA) m_alarm[a-4] = wd;
    end
    m_apend = m_apend | aset;
    m_opend = m_opend | oset;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { bit is_rd; logic [W-1:0] exp; int due; } item_t;
  item_t sb_q[$];
  item_t mon_it;
  bit    mon_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_exp = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      if (rtc_ready || mon_exp) begin
        chk("ready", W'(rtc_ready), W'(mon_exp));
        if (mon_exp) begin
          mon_it = sb_q.pop_front();
          if (mon_it.is_rd) chk("rdata", rtc_rdata, mon_it.exp);
        end
      end
    end
  end

  // One bus cycle; called right after a falling edge, returns at the next one.
  task automatic cyc_op(input bit re, input bit we, input int a, input logic [W-1:0] wd);
    bit rise;
    item_t it;
    rtc_re = re; rtc_we = we; rtc_addr = a[AW-1:0]; rtc_wdata = wd;
    rise = ext_next & ~ext_lvl;
    ext_lvl = ext_next;
`ifdef RTC_EXT_TICK_EN
    rtc_tick_in = ext_lvl;
`endif
    if (re || we) begin
      it.is_rd = re; it.exp = model_read(a); it.due = cyc + 1;
      sb_q.push_back(it);
    end
    model_step(we, a, wd, rise);
    @(posedge clk);
    #1;
    chk("irq", W'(rtc_irq), W'(model_irq()));
    @(negedge clk);
    rtc_re = 1'b0; rtc_we = 1'b0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d); cyc_op(0, 1, a, d); endtask
  task automatic rd(input int a); cyc_op(1, 0, a, '0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc_op(0, 0, 0, '0); endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int r, k, pick;
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", rtc_rdata, '0);
    chk("rst_ready", W'(rtc_ready), '0);
    chk("rst_irq", W'(rtc_irq), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset values, including unmapped words
    for (int a = 0; a < 16; a++) begin rd(a); idle(1); end

    // prescale 3 for 40 clocks, then frozen
    wr(1, 3); wr(0, 1); idle(40); rd(2);
    wr(0, 0); idle(100); rd(2);

    // alarm 0 at 5, W1C, direct COUNT write to the alarm value
    wr(2, 0); wr(4, 5); wr(1, 0); wr(0, 32'h101); idle(8); rd(3);
    wr(3, 1); idle(2); rd(3);
    wr(0, 0); wr(2, 5); rd(3); wr(0, 32'h101); idle(2); rd(3); wr(3, 32'hFFFF_FFFF);

    // overflow, then wrap suppressed by a coincident COUNT write
    wr(0, 0); wr(2, 32'hFFFF_FFFE); wr(0, 32'h10001); idle(3); rd(3); rd(2);
    wr(3, 32'h10000);
    wr(0, 0); wr(2, 32'hFFFF_FFFE); wr(0, 32'h10001); idle(1); wr(2, 32'h1234); rd(3); rd(2);

    // W1C coinciding with the alarm-0 match
    wr(0, 0); wr(2, 0); wr(3, 32'hFFFF_FFFF); wr(4, 5); wr(0, 32'h101);
    idle(4); wr(3, 1); rd(3);
    // read and write PRESCALE together
    cyc_op(1, 1, 1, 7); rd(1);

    // asynchronous reset while counting with irq high
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdata", rtc_rdata, '0);
    chk("midrst_ready", W'(rtc_ready), '0);
    chk("midrst_irq", W'(rtc_irq), '0);
    model_reset();
    sb_q.delete();
    ext_next = 1'b0; ext_lvl = 1'b0;
`ifdef RTC_EXT_TICK_EN
    rtc_tick_in = 1'b0;
`endif
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 6; a++) rd(a);

`ifdef RTC_EXT_TICK_EN
    // eight external edges at PRESCALE=1
    wr(1, 1); wr(2, 0); wr(0, 1);
    for (int e = 0; e < 8; e++) begin
      ext_next = 1'b1; idle(3); ext_next = 1'b0; idle(3);
    end
    idle(6); rd(2);
`endif

    // randomized traffic
    wr(1, 1); wr(4, 20); wr(5, 40); wr(0, 32'h10301);
    for (int n = 0; n < 1500; n++) begin
      if (EXT && $urandom_range(0, 2) == 0) ext_next = ~ext_next;
      r = $urandom_range(0, 19);
      pick = $urandom_range(0, NA - 1);
      if (r <= 7) idle(1);
      else if (r <= 10) rd($urandom_range(0, 15));
      else if (r == 11) begin
        k = $urandom_range(0, 2);
        if (k == 0) wr(2, m_alarm[pick] - W'($urandom_range(0, 6)));
        else if (k == 1) wr(2, 32'hFFFF_FFF8 + W'($urandom_range(0, 7)));
        else wr(2, W'($urandom));
      end
      else if (r == 12) wr(4 + pick, m_cnt + W'($urandom_range(0, 10)));
      else if (r == 13) wr(3, W'($urandom));
      else if (r == 14) wr(0, (W'($urandom_range(0, 1)) << 16) | (W'($urandom_range(0, 3)) << 8)
                              | W'($urandom_range(0, 4) != 0));
      else if (r == 15) wr(1, W'($urandom_range(0, 3)));
      else if (r == 16) cyc_op(1, 1, $urandom_range(0, 7), W'($urandom_range(0, 15)));
      else if (r == 17) wr($urandom_range(6, 15), W'($urandom));
      else rd($urandom_range(2, 3));
    end

    idle(3);
    chk("drain", W'(sb_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
